// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared definitions for the RV32I execute stage.
//   - datapath widths (XLEN, RADDR)
//   - ALUControl operation codes, also used by the ALU decoder
//   - forwarding-select codes for the operand muxes
//   - branch funct3 codes and the branch-condition helper
//   - layout of the EX/MEM pipeline register
package ex_stage_pkg;

    localparam int XLEN  = 32;
    localparam int RADDR = 5;

    // ALUControl encoding
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_SRL  = 4'b1111;

    // Operand forwarding selects; 2'b11 falls back to the register file
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Branch conditions (funct3)
    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    // EX/MEM pipeline register contents
    typedef struct packed {
        logic [XLEN-1:0]  alu_result;
        logic [XLEN-1:0]  write_data;
        logic [RADDR-1:0] rd;
        logic [XLEN-1:0]  pc_plus4;
        logic             reg_write;
        logic             mem_write;
        logic [1:0]       result_src;
    } exmem_t;

    // Branch condition evaluation; the unused funct3 codes 010/011 are never taken.
    function automatic logic branch_cond(input logic [2:0]      funct3,
                                         input logic [XLEN-1:0] a,
                                         input logic [XLEN-1:0] b);
        logic taken;
        taken = 1'b0;
        case (funct3)
            BR_EQ:   taken = (a == b);
            BR_NE:   taken = (a != b);
            BR_LT:   taken = ($signed(a) <  $signed(b));
            BR_GE:   taken = ($signed(a) >= $signed(b));
            BR_LTU:  taken = (a <  b);
            BR_GEU:  taken = (a >= b);
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: bundle of the ID/EX inputs, forwarding inputs and EX/MEM outputs
// of the execute stage.
//   master : upstream pipeline/control side (drives E-stage inputs, observes results)
//   slave  : the execute stage itself
interface ex_stage_if;
    import ex_stage_pkg::*;

    // pipeline register control
    logic             EnM;
    logic             FlushM;
    // ID/EX operands
    logic [XLEN-1:0]  RD1E;
    logic [XLEN-1:0]  RD2E;
    logic [XLEN-1:0]  ImmExtE;
    logic [XLEN-1:0]  PCE;
    logic [XLEN-1:0]  PCPlus4E;
    logic [RADDR-1:0] RdE;
    // ID/EX control
    logic [3:0]       ALUControlE;
    logic [2:0]       funct3E;
    logic             ALUSrcE;
    logic             RegWriteE;
    logic             MemWriteE;
    logic [1:0]       ResultSrcE;
    logic             BranchE;
    logic             JumpE;
    logic             JalrE;
    // forwarding
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic [XLEN-1:0]  ResultW;
    // redirect
    logic             PCSrcE;
    logic [XLEN-1:0]  PCTargetE;
    // EX/MEM outputs
    logic [XLEN-1:0]  ALUResultM;
    logic [XLEN-1:0]  WriteDataM;
    logic [RADDR-1:0] RdM;
    logic [XLEN-1:0]  PCPlus4M;
    logic             RegWriteM;
    logic             MemWriteM;
    logic [1:0]       ResultSrcM;

    modport master (
        output EnM, FlushM, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE,
               ALUControlE, funct3E, ALUSrcE, RegWriteE, MemWriteE, ResultSrcE,
               BranchE, JumpE, JalrE, ForwardAE, ForwardBE, ResultW,
        input  PCSrcE, PCTargetE, ALUResultM, WriteDataM, RdM, PCPlus4M,
               RegWriteM, MemWriteM, ResultSrcM
    );

    modport slave (
        input  EnM, FlushM, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE,
               ALUControlE, funct3E, ALUSrcE, RegWriteE, MemWriteE, ResultSrcE,
               BranchE, JumpE, JalrE, ForwardAE, ForwardBE, ResultW,
        output PCSrcE, PCTargetE, ALUResultM, WriteDataM, RdM, PCPlus4M,
               RegWriteM, MemWriteM, ResultSrcM
    );

endinterface

// File: rtl/ex_stage_alu.sv
// ex_stage_alu: purely combinational RV32I ALU.
//   src_a, src_b : operands (XLEN)
//   alu_control  : 4-bit operation code (ALU_* in ex_stage_pkg)
//   alu_result   : result; unknown codes yield 0
module ex_stage_alu
    import ex_stage_pkg::*;
(
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [3:0]      alu_control,
    output logic [XLEN-1:0] alu_result
);

    logic [4:0] shamt;
    assign shamt = src_b[4:0];

    always_comb begin
        alu_result = '0;
        case (alu_control)
            ALU_ADD:  alu_result = src_a + src_b;
            ALU_SUB:  alu_result = src_a - src_b;
            ALU_AND:  alu_result = src_a & src_b;
            ALU_OR:   alu_result = src_a | src_b;
            ALU_SLL:  alu_result = src_a << shamt;
            ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            ALU_XOR:  alu_result = src_a ^ src_b;
            ALU_SRA:  alu_result = $unsigned($signed(src_a) >>> shamt);
            ALU_SRL:  alu_result = src_a >> shamt;
            default:  alu_result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage RV32I pipeline.
//   clk   : pipeline clock, rising edge
//   reset : asynchronous, active-high; clears the EX/MEM register
//   ex    : ex_stage_if.slave -- ID/EX operands and control, forwarding inputs,
//           combinational redirect (PCSrcE/PCTargetE) and the EX/MEM register outputs
// Operand forwarding, ALU, branch resolution and the EX/MEM register with
// stall (EnM=0) and flush (FlushM=1, which wins over a stall).
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    ex_stage_if.slave   ex
);

    exmem_t exmem_reg;
    exmem_t exmem_next;

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b_fwd;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] pc_sum;
    logic            cond;

    // Forwarding muxes. The M-stage path uses the register's own output.
    always_comb begin
        src_a = ex.RD1E;
        case (ex.ForwardAE)
            FWD_W:   src_a = ex.ResultW;
            FWD_M:   src_a = exmem_reg.alu_result;
            default: src_a = ex.RD1E;
        endcase
    end

    always_comb begin
        src_b_fwd = ex.RD2E;
        case (ex.ForwardBE)
            FWD_W:   src_b_fwd = ex.ResultW;
            FWD_M:   src_b_fwd = exmem_reg.alu_result;
            default: src_b_fwd = ex.RD2E;
        endcase
    end

    assign src_b = ex.ALUSrcE ? ex.ImmExtE : src_b_fwd;

    ex_stage_alu u_alu (
        .src_a       (src_a),
        .src_b       (src_b),
        .alu_control (ex.ALUControlE),
        .alu_result  (alu_result)
    );

    // Branch compare uses the forwarded rs2, never the immediate.
    assign cond      = branch_cond(ex.funct3E, src_a, src_b_fwd);
    assign jalr_sum  = src_a + ex.ImmExtE;
    assign pc_sum    = ex.PCE + ex.ImmExtE;

    assign ex.PCSrcE    = ex.JumpE | (ex.BranchE & cond);
    assign ex.PCTargetE = ex.JalrE ? (jalr_sum & {{(XLEN-1){1'b1}}, 1'b0}) : pc_sum;

    // EX/MEM next-state: flush > load > hold
    always_comb begin
        exmem_next = exmem_reg;
        if (ex.FlushM) begin
            exmem_next = '0;
        end else if (ex.EnM) begin
            exmem_next.alu_result = alu_result;
            exmem_next.write_data = src_b_fwd;
            exmem_next.rd         = ex.RdE;
            exmem_next.pc_plus4   = ex.PCPlus4E;
            exmem_next.reg_write  = ex.RegWriteE;
            exmem_next.mem_write  = ex.MemWriteE;
            exmem_next.result_src = ex.ResultSrcE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exmem_reg <= '0;
        end else begin
            exmem_reg <= exmem_next;
        end
    end

    assign ex.ALUResultM = exmem_reg.alu_result;
    assign ex.WriteDataM = exmem_reg.write_data;
    assign ex.RdM        = exmem_reg.rd;
    assign ex.PCPlus4M   = exmem_reg.pc_plus4;
    assign ex.RegWriteM  = exmem_reg.reg_write;
    assign ex.MemWriteM  = exmem_reg.mem_write;
    assign ex.ResultSrcM = exmem_reg.result_src;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: self-checking bench for ex_stage. Each transaction computes the
// expected redirect and EX/MEM contents from a reference model, pushes the
// expected register image to a queue, and pops/compares it after the edge.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;

    ex_stage_if bus ();

    ex_stage dut (
        .clk   (clk),
        .reset (reset),
        .ex    (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
    } m_t;

    m_t exp_q[$];
    m_t model_m;
    int checks = 0;
    int errors = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_alu(input logic [3:0] code, input logic [31:0] a,
                                              input logic [31:0] b);
        case (code)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return a & b;
            4'b0011: return a | b;
            4'b0100: return a << b[4:0];
            4'b0101: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0110: return (a < b) ? 32'd1 : 32'd0;
            4'b1010: return a ^ b;
            4'b1011: return $unsigned($signed(a) >>> b[4:0]);
            4'b1111: return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_cond(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_fwd(input logic [1:0] sel, input logic [31:0] rf);
        case (sel)
            2'b01:   return bus.ResultW;
            2'b10:   return model_m.alu;
            default: return rf;
        endcase
    endfunction

    task automatic clear_inputs();
        bus.EnM = 1'b1;        bus.FlushM = 1'b0;
        bus.RD1E = '0;         bus.RD2E = '0;       bus.ImmExtE = '0;
        bus.PCE = '0;          bus.PCPlus4E = '0;   bus.RdE = '0;
        bus.ALUControlE = '0;  bus.funct3E = '0;    bus.ALUSrcE = 1'b0;
        bus.RegWriteE = 1'b0;  bus.MemWriteE = 1'b0; bus.ResultSrcE = '0;
        bus.BranchE = 1'b0;    bus.JumpE = 1'b0;    bus.JalrE = 1'b0;
        bus.ForwardAE = '0;    bus.ForwardBE = '0;  bus.ResultW = '0;
    endtask

    task automatic check_m(input string name);
        m_t e;
        if (exp_q.size() == 0) begin
            check_value({name, ":queue_empty"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check_value({name, ":alu"}, bus.ALUResultM, e.alu);
        check_value({name, ":wd"},  bus.WriteDataM, e.wd);
        check_value({name, ":rd"},  {27'd0, bus.RdM}, {27'd0, e.rd});
        check_value({name, ":pc4"}, bus.PCPlus4M, e.pc4);
        check_value({name, ":rw"},  {31'd0, bus.RegWriteM}, {31'd0, e.rw});
        check_value({name, ":mw"},  {31'd0, bus.MemWriteM}, {31'd0, e.mw});
        check_value({name, ":rs"},  {30'd0, bus.ResultSrcM}, {30'd0, e.rs});
        model_m = e;
    endtask

    // Inputs must already be driven; checks redirect, then the registered result after the edge.
    task automatic step(input string name);
        logic [31:0] a, bf, b, tgt;
        logic        pcsrc;
        m_t          nxt;
        #1;
        a     = model_fwd(bus.ForwardAE, bus.RD1E);
        bf    = model_fwd(bus.ForwardBE, bus.RD2E);
        b     = bus.ALUSrcE ? bus.ImmExtE : bf;
        pcsrc = bus.JumpE | (bus.BranchE & model_cond(bus.funct3E, a, bf));
        tgt   = bus.JalrE ? ((a + bus.ImmExtE) & 32'hFFFF_FFFE) : (bus.PCE + bus.ImmExtE);
        check_value({name, ":pcsrc"},  {31'd0, bus.PCSrcE}, {31'd0, pcsrc});
        check_value({name, ":target"}, bus.PCTargetE, tgt);
        nxt = model_m;
        if (bus.FlushM) begin
            nxt = '0;
        end else if (bus.EnM) begin
            nxt.alu = model_alu(bus.ALUControlE, a, b);
            nxt.wd  = bf;
            nxt.rd  = bus.RdE;
            nxt.pc4 = bus.PCPlus4E;
            nxt.rw  = bus.RegWriteE;
            nxt.mw  = bus.MemWriteE;
            nxt.rs  = bus.ResultSrcE;
        end
        exp_q.push_back(nxt);
        @(posedge clk);
        #1;
        check_m(name);
        $display("txn %-10s alu=%h rd=%0d pcsrc=%b target=%h", name, bus.ALUResultM, bus.RdM,
                 bus.PCSrcE, bus.PCTargetE);
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        model_m = '0;
        #12;
        // reset state
        exp_q.push_back('0);
        check_m("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // sub, then forward its result back into operand A
        bus.ALUControlE = ALU_SUB; bus.RD1E = 32'd5; bus.RD2E = 32'd7;
        bus.RdE = 5'd3; bus.RegWriteE = 1'b1; bus.PCPlus4E = 32'h104;
        step("sub");
        bus.ForwardAE = FWD_M;
        step("sub_fwd");
        bus.ForwardAE = FWD_RF;

        // sra vs srl
        bus.RD1E = 32'h8000_0000; bus.ImmExtE = 32'd4; bus.ALUSrcE = 1'b1;
        bus.ALUControlE = ALU_SRA;
        step("sra");
        bus.ALUControlE = ALU_SRL;
        step("srl");

        // signed vs unsigned less-than branches
        clear_inputs();
        bus.RD1E = 32'hFFFF_FFFF; bus.RD2E = 32'd1; bus.PCE = 32'h100; bus.ImmExtE = 32'h20;
        bus.BranchE = 1'b1; bus.funct3E = BR_LT;
        step("blt");
        bus.funct3E = BR_LTU;
        step("bltu");

        // jalr clears the target LSB
        clear_inputs();
        bus.JalrE = 1'b1; bus.JumpE = 1'b1; bus.RD1E = 32'h1003; bus.ImmExtE = 32'd4;
        bus.PCPlus4E = 32'h208; bus.RdE = 5'd1; bus.RegWriteE = 1'b1; bus.ResultSrcE = 2'b10;
        step("jalr");

        // stall: outputs hold while inputs change
        clear_inputs();
        bus.RD1E = 32'h55; bus.RD2E = 32'h66; bus.RdE = 5'd9; bus.MemWriteE = 1'b1;
        bus.PCPlus4E = 32'h300;
        bus.EnM = 1'b0;
        step("stall1");
        bus.RD1E = 32'h77; bus.RdE = 5'd10; bus.ALUControlE = ALU_XOR;
        step("stall2");
        // flush wins over stall
        bus.FlushM = 1'b1;
        step("flush");

        // random mix including forwarding, stalls and flushes
        for (int i = 0; i < 40; i++) begin
            bus.RD1E = $urandom; bus.RD2E = $urandom; bus.ImmExtE = $urandom;
            bus.PCE = $urandom; bus.PCPlus4E = $urandom; bus.ResultW = $urandom;
            bus.RdE = 5'($urandom_range(0, 31));
            bus.ALUControlE = 4'($urandom_range(0, 15));
            bus.funct3E = 3'($urandom_range(0, 7));
            bus.ALUSrcE = 1'($urandom_range(0, 1));
            bus.RegWriteE = 1'($urandom_range(0, 1));
            bus.MemWriteE = 1'($urandom_range(0, 1));
            bus.ResultSrcE = 2'($urandom_range(0, 3));
            bus.BranchE = 1'($urandom_range(0, 1));
            bus.JumpE = ($urandom_range(0, 3) == 0);
            bus.JalrE = 1'($urandom_range(0, 1));
            bus.ForwardAE = 2'($urandom_range(0, 3));
            bus.ForwardBE = 2'($urandom_range(0, 3));
            bus.EnM = ($urandom_range(0, 3) != 0);
            bus.FlushM = ($urandom_range(0, 7) == 0);
            step("rand");
        end

        // asynchronous reset between edges
        clear_inputs();
        bus.RD1E = 32'h1234; bus.RegWriteE = 1'b1; bus.RdE = 5'd4;
        step("load1234");
        #2;
        reset = 1'b1;
        #1;
        check_value("async_alu", bus.ALUResultM, 32'd0);
        check_value("async_rw", {31'd0, bus.RegWriteM}, 32'd0);
        model_m = '0;
        exp_q.delete();
        #1;
        reset = 1'b0;
        bus.EnM = 1'b0;
        step("post_rst");
        bus.EnM = 1'b1;
        step("post_en");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", 0, 1);
        $fatal(1, "timeout");
    end

endmodule
